// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the IF stage: datapath width, instruction width, reset PC and bubble encoding.
package if_fetch_stage_pkg;
  localparam int          DEF_XLEN      = 32;
  localparam int          INSTR_WIDTH   = 32;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {pc, instr} holding register; load/drain take effect at the next edge.
// Backpressure: none; the caller guarantees load is never asserted while full.
module if_skid_buffer
  import if_fetch_stage_pkg::*;
#(
  parameter int PC_W    = DEF_XLEN,
  parameter int INSTR_W = INSTR_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [PC_W-1:0]    load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               skid_vld,
  output logic [PC_W-1:0]    skid_pc,
  output logic [INSTR_W-1:0] skid_instr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_vld   <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (clear) begin
      skid_vld <= 1'b0;
    end else if (load) begin
      skid_vld   <= 1'b1;
      skid_pc    <= load_pc;
      skid_instr <= load_instr;
    end else if (drain) begin
      skid_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch PC + IF/ID register; fetch at cycle N lands in IF/ID after the edge ending N+1, 1 instr/cycle.
// Stall holds PC and IF/ID, parking the in-flight response in a skid entry; IF_PERF_CNT_EN adds flush/stall counters.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int                      XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0]         RESET_PC  = DEF_RESET_PC,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   IF_flush,
  input  logic [XLEN-1:0]        branch_target,
  input  logic                   Stall,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [XLEN-1:0]        IF_ID_pc,
  output logic [INSTR_WIDTH-1:0] IF_ID_instr,
  output logic                   IF_ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            flush_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  logic [XLEN-1:0]        fetch_pc;
  logic                   resp_valid;
  logic [XLEN-1:0]        resp_pc;
  logic                   skid_vld;
  logic [XLEN-1:0]        skid_pc;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic                   advance;

  assign advance   = !IF_flush && !Stall;
  assign imem_req  = rst_n && !Stall;
  assign imem_addr = fetch_pc;

  // Only the first stall cycle can see a live response, so the skid is never overwritten.
  if_skid_buffer #(
    .PC_W    (XLEN),
    .INSTR_W (INSTR_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (!IF_flush && Stall && resp_valid),
    .drain      (advance),
    .clear      (IF_flush),
    .load_pc    (resp_pc),
    .load_instr (imem_rdata),
    .skid_vld   (skid_vld),
    .skid_pc    (skid_pc),
    .skid_instr (skid_instr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_valid  <= 1'b0;
      resp_pc     <= '0;
      IF_ID_pc    <= '0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
    end else if (IF_flush) begin
      // Dropping resp_valid discards the wrong-path fetch issued this cycle.
      fetch_pc    <= branch_target;
      resp_valid  <= 1'b0;
      IF_ID_pc    <= '0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
    end else if (Stall) begin
      resp_valid <= 1'b0;
    end else begin
      if (skid_vld) begin
        IF_ID_pc    <= skid_pc;
        IF_ID_instr <= skid_instr;
        IF_ID_valid <= 1'b1;
      end else begin
        IF_ID_pc    <= resp_pc;
        IF_ID_instr <= resp_valid ? imem_rdata : NOP_INSTR;
        IF_ID_valid <= resp_valid;
      end
      fetch_pc   <= fetch_pc + XLEN'(4);
      resp_valid <= 1'b1;
      resp_pc    <= fetch_pc;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (IF_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
      if (!IF_flush && Stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed + random bench for if_fetch_stage with a queue-based fetch model and per-cycle compare.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        IF_flush = 1'b0;
  logic        Stall = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] flush_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  if_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IF_flush      (IF_flush),
    .branch_target (branch_target),
    .Stall         (Stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_instr   (IF_ID_instr),
    .IF_ID_valid   (IF_ID_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .flush_cnt     (flush_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0000} ^ a ^ 32'h5A5A_0000;
  endfunction

  // Synchronous imem: data for a requested address one cycle later, garbage otherwise.
  always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom();

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: addresses already requested but not yet delivered form an in-order queue.
  logic [31:0] m_fpc;
  logic [31:0] m_q[$];
  logic        m_v;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_fcnt;
  logic [31:0] m_scnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fpc = 32'h0; m_q.delete(); m_v = 1'b0; m_pc = '0; m_instr = NOP;
      m_fcnt = '0; m_scnt = '0;
    end else if (IF_flush) begin
      m_q.delete(); m_v = 1'b0; m_pc = '0; m_instr = NOP; m_fpc = branch_target;
      if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
    end else if (Stall) begin
      if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
    end else begin
      if (m_q.size() > 0) begin
        m_pc = m_q.pop_front(); m_instr = mem_word(m_pc); m_v = 1'b1;
      end else begin
        m_v = 1'b0; m_instr = NOP;
      end
      m_q.push_back(m_fpc);
      m_fpc = m_fpc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, !Stall});
      chk("imem_addr", imem_addr, m_fpc);
      chk("IF_ID_valid", {31'b0, IF_ID_valid}, {31'b0, m_v});
      chk("IF_ID_instr", IF_ID_instr, m_instr);
      if (m_v) chk("IF_ID_pc", IF_ID_pc, m_pc);
`ifdef IF_PERF_CNT_EN
      chk("flush_cnt", flush_cnt, m_fcnt);
      chk("stall_cnt", stall_cnt, m_scnt);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string name, input logic [31:0] pc);
    chk({name, "_valid"}, {31'b0, IF_ID_valid}, 32'd1);
    chk({name, "_pc"}, IF_ID_pc, pc);
    chk({name, "_instr"}, IF_ID_instr, mem_word(pc));
  endtask

  task automatic chk_bubble(input string name);
    chk({name, "_valid"}, {31'b0, IF_ID_valid}, 32'd0);
    chk({name, "_instr"}, IF_ID_instr, NOP);
  endtask

  task automatic chk_reset_vals(input string name);
    chk_bubble(name);
    chk({name, "_pc"}, IF_ID_pc, 32'h0);
    chk({name, "_req"}, {31'b0, imem_req}, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk({name, "_fcnt"}, flush_cnt, 32'd0);
    chk({name, "_scnt"}, stall_cnt, 32'd0);
`endif
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick();
    chk_reset_vals("rst");
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_req", {31'b0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);

    // Straight-line fetch after reset
    tick(); chk_bubble("first_edge");
    tick(); chk_ifid("seq0", 32'h0);
    tick(); chk_ifid("seq4", 32'h4);
    tick(); chk_ifid("seq8", 32'h8);

    // Three-cycle stall while IF/ID holds 8
    Stall = 1'b1;
    #1 chk("stall_req", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_ifid("stall_hold", 32'h8);
    end
    Stall = 1'b0;
    tick(); chk_ifid("rel12", 32'hC);
    tick(); chk_ifid("rel16", 32'h10);
    for (int i = 0; i < 4; i++) tick();
    chk_ifid("at20", 32'h20);

    // Taken branch to 0x100
    IF_flush = 1'b1; branch_target = 32'h100;
    tick(); chk_bubble("flush0");
    IF_flush = 1'b0;
    tick(); chk_bubble("flush1");
    tick(); chk_ifid("target", 32'h100);

    // Flush and stall together with the skid full
    Stall = 1'b1;
    tick();
    IF_flush = 1'b1; branch_target = 32'h200;
    tick(); chk_bubble("fs0");
    IF_flush = 1'b0; Stall = 1'b0;
    tick(); chk_bubble("fs1");
    tick(); chk_ifid("fs_target", 32'h200);

    // PC wrap
    IF_flush = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    IF_flush = 1'b0;
    #1 chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick(); chk("wrap_addr1", imem_addr, 32'h0);
    tick(); chk_ifid("wrap_top", 32'hFFFF_FFFC);
    tick(); chk_ifid("wrap_zero", 32'h0);

    // Reset mid-stall with the skid full
    Stall = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    tick();
    rst_n = 1'b1; Stall = 1'b0;
    #1 chk("midrst_addr", imem_addr, 32'h0);

    // One flush then a three-cycle stall for the counters
    IF_flush = 1'b1; branch_target = 32'h40;
    tick();
    IF_flush = 1'b0; Stall = 1'b1;
    tick(); tick(); tick();
    Stall = 1'b0;
    tick();
`ifdef IF_PERF_CNT_EN
    chk("cnt_flush", flush_cnt, 32'd1);
    chk("cnt_stall", stall_cnt, 32'd3);
`endif
    tick(); chk_ifid("cnt_target", 32'h40);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      IF_flush = ($urandom_range(0, 99) < 6);
      Stall = ($urandom_range(0, 99) < 20);
      branch_target = ($urandom_range(0, 9) == 0) ? $urandom() : ($urandom() & 32'h0000_0FFC);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    IF_flush = 1'b0; Stall = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
